// File: rtl/wbuf_pkg.sv
// Shared definitions for the ping-pong weight buffer.
//   - default widths for the buffer geometry
//   - read-side FSM state encoding
//   - lane_stage(): which skew-chain stage feeds a given lane
package wbuf_pkg;

    localparam int WBUF_NUM_LANES   = 16;
    localparam int WBUF_LANE_DATA_W = 64;
    localparam int WBUF_ADDR_W      = 9;
    localparam int WBUF_FC_GROUP    = 4;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACTIVE = 2'd1,
        RD_DRAIN  = 2'd2
    } rd_state_e;

    // Conv mode: every lane has its own stage. FC mode: a group of lanes shares one.
    function automatic int lane_stage(input int lane, input logic fc_mode, input int fc_group);
        return fc_mode ? (lane / fc_group) : lane;
    endfunction

endpackage

// File: rtl/wbuf_lane_ram.sv
// Single-lane weight RAM holding both ping-pong halves.
//   clk      : clock
//   wr_en    : write strobe; wr_addr = {half, word}, wr_data = word to store
//   rd_en    : read strobe;  rd_addr = {half, word}
//   rd_data  : registered read data, updated one cycle after rd_en, held otherwise
// No reset: contents and read register are undefined until written/read.
module wbuf_lane_ram
    import wbuf_pkg::*;
#(
    parameter int DATA_W = WBUF_LANE_DATA_W,
    parameter int ADDR_W = WBUF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 * (2 ** ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/wbuf_pingpong.sv
// Ping-pong weight buffer between the weight DMA and the systolic array.
// One RAM per lane, each split into two halves: the DMA fills one half while the
// array reads the other. Read requests enter at lane 0 and ripple down a skew chain
// (1 stage per lane in conv mode, 1 stage per FC_GROUP lanes in FC mode).
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   mem_write_req/addr/data         DMA writes; addr = {word, lane id}
//   fill_done, wr_ready             write-half handshake
//   buf_read_req/addr, read_done    read requests at lane 0, end-of-tile pulse
//   rd_ready                        read half holds a full tile
//   fc                              skew mode, sampled at tile start
//   buf_read_data, weight_valid     per-lane registered read data / valid
//   wr_drop_err                     sticky: write attempted while wr_ready=0
//   err_cnt                         only with WBUF_ERR_CNT_EN: saturating count of
//                                   dropped writes plus ignored read requests
//
// Read FSM:
//   state     | meaning
//   RD_IDLE   | waiting for first request of a tile on a full half
//   RD_ACTIVE | requests injected into the skew chain
//   RD_DRAIN  | tile issued; wait for chain and RAM stage to empty, then release half
module wbuf_pingpong
    import wbuf_pkg::*;
#(
    parameter int NUM_LANES   = WBUF_NUM_LANES,
    parameter int LANE_DATA_W = WBUF_LANE_DATA_W,
    parameter int ADDR_W      = WBUF_ADDR_W,
    parameter int FC_GROUP    = WBUF_FC_GROUP,
    parameter int LANE_ID_W   = $clog2(NUM_LANES),
    parameter int MEM_ADDR_W  = ADDR_W + LANE_ID_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             mem_write_req,
    input  logic [MEM_ADDR_W-1:0]            mem_write_addr,
    input  logic [LANE_DATA_W-1:0]           mem_write_data,
    input  logic                             fill_done,
    output logic                             wr_ready,
    input  logic                             buf_read_req,
    input  logic [ADDR_W-1:0]                buf_read_addr,
    input  logic                             read_done,
    output logic                             rd_ready,
    input  logic                             fc,
    output logic [NUM_LANES*LANE_DATA_W-1:0] buf_read_data,
    output logic [NUM_LANES-1:0]             weight_valid,
    output logic                             wr_drop_err
`ifdef WBUF_ERR_CNT_EN
    ,
    output logic [15:0]                      err_cnt
`endif
);

    rd_state_e state_q, state_d;
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;
    logic fc_q, fc_d;
    logic wr_drop_err_q, wr_drop_err_d;
    logic [1:0] bank_full_q, bank_full_d;

    logic [NUM_LANES-1:1] chain_req_q, chain_req_d;
    logic [ADDR_W-1:0]    chain_addr_q [1:NUM_LANES-1];
    logic [ADDR_W-1:0]    chain_addr_d [1:NUM_LANES-1];
    logic [NUM_LANES-1:0] chain_req;
    logic [ADDR_W-1:0]    chain_addr [NUM_LANES];

    logic [NUM_LANES-1:0]             lane_rd_en;
    logic [ADDR_W-1:0]                lane_rd_addr [NUM_LANES];
    logic [NUM_LANES*LANE_DATA_W-1:0] ram_rd_data;
    logic [NUM_LANES-1:0]             ram_vld_q, ram_vld_d;
    logic [NUM_LANES*LANE_DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_LANES-1:0]             weight_valid_q, weight_valid_d;

    logic inject, drain_done, chain_idle, fc_sel;
    logic wr_ok, wr_drop, fill_ok;
    logic [LANE_ID_W-1:0] wr_lane;
    logic [ADDR_W-1:0]    wr_word;

    assign wr_ready = ~bank_full_q[wr_bank_q];
    assign rd_ready = bank_full_q[rd_bank_q];
    assign wr_ok    = mem_write_req & wr_ready;
    assign wr_drop  = mem_write_req & ~wr_ready;
    assign fill_ok  = fill_done & wr_ready;
    assign wr_lane  = mem_write_addr[LANE_ID_W-1:0];
    assign wr_word  = mem_write_addr[MEM_ADDR_W-1:LANE_ID_W];

    assign chain_idle = ~(|chain_req_q) & ~(|ram_vld_q);
    // The first request of a tile is read at stage 0 in the same cycle fc is latched.
    assign fc_sel = (state_q == RD_IDLE) ? fc : fc_q;

    always_comb begin
        state_d    = state_q;
        fc_d       = fc_q;
        inject     = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (buf_read_req && rd_ready) begin
                    inject  = 1'b1;
                    fc_d    = fc;
                    state_d = RD_ACTIVE;
                end
            end
            RD_ACTIVE: begin
                inject = buf_read_req;
                if (read_done) state_d = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (chain_idle) begin
                    drain_done = 1'b1;
                    state_d    = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        bank_full_d   = bank_full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_drop_err_d = wr_drop_err_q | wr_drop;
        if (fill_ok) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (drain_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    always_comb begin
        chain_req[0]  = inject;
        chain_addr[0] = buf_read_addr;
        for (int k = 1; k < NUM_LANES; k++) begin
            chain_req[k]  = chain_req_q[k];
            chain_addr[k] = chain_addr_q[k];
        end
    end

    always_comb begin
        chain_req_d = '0;
        for (int k = 1; k < NUM_LANES; k++) begin
            chain_req_d[k]  = chain_req[k-1];
            chain_addr_d[k] = chain_addr[k-1];
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int S_CONV = lane_stage(i, 1'b0, FC_GROUP);
        localparam int S_FC   = lane_stage(i, 1'b1, FC_GROUP);

        assign lane_rd_en[i]   = fc_sel ? chain_req[S_FC]  : chain_req[S_CONV];
        assign lane_rd_addr[i] = fc_sel ? chain_addr[S_FC] : chain_addr[S_CONV];

        wbuf_lane_ram #(
            .DATA_W (LANE_DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_ok && (wr_lane == LANE_ID_W'(i))),
            .wr_addr ({wr_bank_q, wr_word}),
            .wr_data (mem_write_data),
            .rd_en   (lane_rd_en[i]),
            .rd_addr ({rd_bank_q, lane_rd_addr[i]}),
            .rd_data (ram_rd_data[i*LANE_DATA_W +: LANE_DATA_W])
        );
    end

    // Output stage holds the last word of a lane while it is not valid.
    always_comb begin
        ram_vld_d      = lane_rd_en;
        weight_valid_d = ram_vld_q;
        rd_data_d      = rd_data_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (ram_vld_q[i])
                rd_data_d[i*LANE_DATA_W +: LANE_DATA_W] = ram_rd_data[i*LANE_DATA_W +: LANE_DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RD_IDLE;
            fc_q           <= 1'b0;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            bank_full_q    <= 2'b00;
            wr_drop_err_q  <= 1'b0;
            chain_req_q    <= '0;
            for (int k = 1; k < NUM_LANES; k++) chain_addr_q[k] <= '0;
            ram_vld_q      <= '0;
            weight_valid_q <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            fc_q           <= fc_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            bank_full_q    <= bank_full_d;
            wr_drop_err_q  <= wr_drop_err_d;
            chain_req_q    <= chain_req_d;
            for (int k = 1; k < NUM_LANES; k++) chain_addr_q[k] <= chain_addr_d[k];
            ram_vld_q      <= ram_vld_d;
            weight_valid_q <= weight_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign buf_read_data = rd_data_q;
    assign weight_valid  = weight_valid_q;
    assign wr_drop_err   = wr_drop_err_q;

`ifdef WBUF_ERR_CNT_EN
    logic        rd_ignored;
    logic [16:0] err_sum;
    logic [15:0] err_cnt_q, err_cnt_d;

    assign rd_ignored = buf_read_req &
                        (((state_q == RD_IDLE) & ~rd_ready) | (state_q == RD_DRAIN));

    always_comb begin
        err_sum   = 17'(err_cnt_q) + 17'(wr_drop) + 17'(rd_ignored);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_wbuf_pingpong.sv
module tb_wbuf_pingpong;

    localparam int NL  = 16;
    localparam int DW  = 64;
    localparam int AW  = 9;
    localparam int FG  = 4;
    localparam int LW  = 4;
    localparam int MAW = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_write_req;
    logic [MAW-1:0]    mem_write_addr;
    logic [DW-1:0]     mem_write_data;
    logic              fill_done;
    logic              wr_ready;
    logic              buf_read_req;
    logic [AW-1:0]     buf_read_addr;
    logic              read_done;
    logic              rd_ready;
    logic              fc;
    logic [NL*DW-1:0]  buf_read_data;
    logic [NL-1:0]     weight_valid;
    logic              wr_drop_err;

    int n_cmp = 0;
    int n_err = 0;

    wbuf_pingpong dut (
        .clk            (clk),
        .reset          (reset),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .fill_done      (fill_done),
        .wr_ready       (wr_ready),
        .buf_read_req   (buf_read_req),
        .buf_read_addr  (buf_read_addr),
        .read_done      (read_done),
        .rd_ready       (rd_ready),
        .fc             (fc),
        .buf_read_data  (buf_read_data),
        .weight_valid   (weight_valid),
        .wr_drop_err    (wr_drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [63:0] exp_word(input int tag, input int lane, input int addr);
        return 64'((tag << 16) | (lane << 8) | addr);
    endfunction

    function automatic logic [63:0] lane_data(input int i);
        return buf_read_data[i*DW +: DW];
    endfunction

    function automatic int stg(input int lane, input logic fcv);
        return fcv ? lane / FG : lane;
    endfunction

    task automatic fill(input int tag);
        for (int a = 0; a < 4; a++) begin
            for (int l = 0; l < NL; l++) begin
                mem_write_req  = 1'b1;
                mem_write_addr = MAW'((a << LW) | l);
                mem_write_data = exp_word(tag, l, a);
                step();
            end
        end
        mem_write_req = 1'b0;
        fill_done     = 1'b1;
        step();
        fill_done     = 1'b0;
    endtask

    // One request at k=0, read_done at k=1; checks every lane's valid/data timing.
    task automatic read_tile(input int addr, input logic fcv, input int tag,
                             input logic next_full, input logic wr_before);
        logic [NL-1:0] ev;
        int n;
        buf_read_req  = 1'b1;
        buf_read_addr = AW'(addr);
        fc            = fcv;
        step();
        buf_read_req = 1'b0;
        read_done    = 1'b1;
        for (int k = 1; k <= NL + 3; k++) begin
            if (k == 2) read_done = 1'b0;
            ev = '0;
            for (int i = 0; i < NL; i++) if (k == 2 + stg(i, fcv)) ev[i] = 1'b1;
            chk("tile_vld", 64'(weight_valid), 64'(ev));
            for (int i = 0; i < NL; i++)
                if (ev[i]) chk("tile_data", lane_data(i), exp_word(tag, i, addr));
            if (!fcv) begin
                chk("tile_rd_ready", 64'(rd_ready), 64'((k <= NL + 1) ? 1'b1 : next_full));
                chk("tile_wr_ready", 64'(wr_ready), 64'((k <= NL + 1) ? wr_before : 1'b1));
            end
            step();
        end
        if (!next_full) begin
            n = 0;
            while (rd_ready && n < 40) begin
                step();
                n++;
            end
            chk("drain_done", 64'(rd_ready), 64'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL-1:0] ev;
        logic [63:0]   ed;
        int n;
        reset          = 1'b1;
        mem_write_req  = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        fill_done      = 1'b0;
        buf_read_req   = 1'b0;
        buf_read_addr  = '0;
        read_done      = 1'b0;
        fc             = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        chk("rst_wr_ready", 64'(wr_ready), 64'(1));
        chk("rst_rd_ready", 64'(rd_ready), 64'(0));
        chk("rst_vld", 64'(weight_valid), 64'(0));
        chk("rst_data", 64'(|buf_read_data), 64'(0));
        chk("rst_drop_err", 64'(wr_drop_err), 64'(0));

        // Request with no full half is ignored.
        buf_read_req = 1'b1;
        step();
        buf_read_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ign_vld", 64'(weight_valid), 64'(0));
            step();
        end

        // Half 0, conv read of addr 2; drain timing.
        fill(0);
        chk("fill0_rd_ready", 64'(rd_ready), 64'(1));
        chk("fill0_wr_ready", 64'(wr_ready), 64'(1));
        read_tile(2, 1'b0, 0, 1'b0, 1'b1);

        // Half 1, FC read: addr 1 then addr 3 with fc flipped to 0 mid-tile.
        fill(1);
        chk("fill1_rd_ready", 64'(rd_ready), 64'(1));
        buf_read_req  = 1'b1;
        buf_read_addr = AW'(1);
        fc            = 1'b1;
        step();
        buf_read_addr = AW'(3);
        fc            = 1'b0;
        read_done     = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            if (k == 2) begin
                buf_read_req = 1'b0;
                read_done    = 1'b0;
            end
            ev = '0;
            for (int i = 0; i < NL; i++) begin
                if (k == 2 + i / FG) begin
                    ev[i] = 1'b1;
                    chk("fc_data_a1", lane_data(i), exp_word(1, i, 1));
                end else if (k == 3 + i / FG) begin
                    ev[i] = 1'b1;
                    chk("fc_data_a3", lane_data(i), exp_word(1, i, 3));
                end
            end
            chk("fc_vld", 64'(weight_valid), 64'(ev));
            if (k == 7) begin
                chk("hold_lane0", lane_data(0), exp_word(1, 0, 3));
                chk("hold_lane15", lane_data(15), exp_word(1, 15, 3));
            end
            step();
        end
        n = 0;
        while (rd_ready && n < 40) begin
            step();
            n++;
        end
        chk("fc_drain", 64'(rd_ready), 64'(0));

        // Both halves full: drop a write, ignore fill_done, read both back.
        fill(2);
        fill(3);
        chk("both_wr_ready", 64'(wr_ready), 64'(0));
        chk("both_rd_ready", 64'(rd_ready), 64'(1));
        mem_write_req  = 1'b1;
        mem_write_addr = MAW'((2 << LW) | 5);
        mem_write_data = 64'hDEAD_BEEF;
        step();
        mem_write_req = 1'b0;
        chk("drop_err", 64'(wr_drop_err), 64'(1));
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("ign_fill_wr_ready", 64'(wr_ready), 64'(0));
        read_tile(2, 1'b0, 2, 1'b1, 1'b0);
        read_tile(2, 1'b1, 3, 1'b0, 1'b1);
        chk("after_both_wr_ready", 64'(wr_ready), 64'(1));

        // Async reset with 5 requests in flight.
        fill(4);
        chk("pre_rst_drop_err", 64'(wr_drop_err), 64'(1));
        fc = 1'b0;
        for (int j = 0; j < 5; j++) begin
            buf_read_req  = 1'b1;
            buf_read_addr = AW'(j);
            step();
        end
        buf_read_req = 1'b0;
        chk("inflight_vld", 64'(weight_valid), 64'(16'h000F));
        ed = exp_word(4, 0, 3);
        chk("inflight_lane0", lane_data(0), ed);
        #2 reset = 1'b1;
        #1;
        chk("arst_vld", 64'(weight_valid), 64'(0));
        chk("arst_data", 64'(|buf_read_data), 64'(0));
        chk("arst_rd_ready", 64'(rd_ready), 64'(0));
        chk("arst_wr_ready", 64'(wr_ready), 64'(1));
        chk("arst_drop_err", 64'(wr_drop_err), 64'(0));
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_vld", 64'(weight_valid), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
